// File: rtl/imm_pkg.sv
// Shared constants for the immediate generator: format codes, RV opcodes,
// and parameter legality helpers.
package imm_pkg;

    // Format select / applied-format encoding. Codes 000-011 keep the old 2-bit ImmSel meaning.
    localparam logic [2:0] IMM_I     = 3'b000;
    localparam logic [2:0] IMM_S     = 3'b001;
    localparam logic [2:0] IMM_B     = 3'b010;
    localparam logic [2:0] IMM_J     = 3'b011;
    localparam logic [2:0] IMM_U     = 3'b100;
    localparam logic [2:0] IMM_SHAMT = 3'b101;
    localparam logic [2:0] IMM_ZIMM  = 3'b110;
    localparam logic [2:0] IMM_NONE  = 3'b111;

    // RV32/RV64 base opcodes that carry an immediate.
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    function automatic bit xlen_legal(int unsigned xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

    function automatic bit depth_legal(int unsigned depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/imm_expand.sv
// Combinational immediate expansion: picks the format (explicit select or
// opcode auto-decode) and builds the sign/zero-extended XLEN-bit immediate.
module imm_expand
    import imm_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter bit          AUTO_DECODE = 1'b1
) (
    input  logic [31:0]     inst_i,
    input  logic [2:0]      sel_i,
    output logic [XLEN-1:0] imm_o,
    output logic [2:0]      fmt_o,
    output logic            illegal_o
);

    logic [31:0] imm32;

    // Format selection: opcode decode when AUTO_DECODE, otherwise the explicit select.
    always_comb begin
        fmt_o     = sel_i;
        illegal_o = 1'b0;
        if (AUTO_DECODE) begin
            case (inst_i[6:0])
                OPC_OP_IMM: begin
                    // slli/srli/srai carry a shift amount instead of a 12-bit immediate
                    if (inst_i[14:12] == 3'b001 || inst_i[14:12] == 3'b101) begin
                        fmt_o = IMM_SHAMT;
                    end else begin
                        fmt_o = IMM_I;
                    end
                end
                OPC_LOAD, OPC_JALR:  fmt_o = IMM_I;
                OPC_STORE:           fmt_o = IMM_S;
                OPC_BRANCH:          fmt_o = IMM_B;
                OPC_JAL:             fmt_o = IMM_J;
                OPC_LUI, OPC_AUIPC:  fmt_o = IMM_U;
                OPC_SYSTEM: begin
                    // CSR*I variants use rs1 field as a 5-bit zero-extended immediate
                    fmt_o = inst_i[14] ? IMM_ZIMM : IMM_I;
                end
                default: begin
                    fmt_o     = IMM_NONE;
                    illegal_o = 1'b1;
                end
            endcase
        end
    end

    // Build a 32-bit immediate, then widen from bit 31 (zero-extended formats have bit 31 clear).
    always_comb begin
        imm32 = '0;
        case (fmt_o)
            IMM_I: imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
            IMM_S: imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            IMM_B: imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                            inst_i[11:8], 1'b0};
            IMM_J: imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                            inst_i[30:21], 1'b0};
            IMM_U: imm32 = {inst_i[31:12], 12'b0};
            IMM_SHAMT: begin
                if (XLEN == 64) begin
                    imm32 = {26'b0, inst_i[25:20]};
                end else begin
                    imm32 = {27'b0, inst_i[24:20]};
                end
            end
            IMM_ZIMM: imm32 = {27'b0, inst_i[19:15]};
            default:  imm32 = '0;
        endcase
        imm_o = {{(XLEN - 31){imm32[31]}}, imm32[30:0]};
    end

endmodule

// File: rtl/imm_gen_stage.sv
// Pipelined immediate generator: expands at push time and buffers
// {imm, fmt, illegal, tag} in a DEPTH-entry register FIFO with valid/ready on both sides.
module imm_gen_stage
    import imm_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned DEPTH       = 2,
    parameter int unsigned TAG_W       = 32,
    parameter bit          AUTO_DECODE = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [2:0]       in_sel,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PtrOne  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CntFull = CNT_W'(DEPTH);

    if (!xlen_legal(XLEN)) begin : g_bad_xlen
        $error("imm_gen_stage: XLEN must be 32 or 64");
    end
    if (!depth_legal(DEPTH)) begin : g_bad_depth
        $error("imm_gen_stage: DEPTH must be a power of two >= 2");
    end

    logic [XLEN-1:0] exp_imm;
    logic [2:0]      exp_fmt;
    logic            exp_illegal;

    imm_expand #(
        .XLEN        (XLEN),
        .AUTO_DECODE (AUTO_DECODE)
    ) u_expand (
        .inst_i    (in_inst),
        .sel_i     (in_sel),
        .imm_o     (exp_imm),
        .fmt_o     (exp_fmt),
        .illegal_o (exp_illegal)
    );

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;

    logic [XLEN-1:0]  imm_q [DEPTH];
    logic [2:0]       fmt_q [DEPTH];
    logic             ill_q [DEPTH];
    logic [TAG_W-1:0] tag_q [DEPTH];

    logic push, pop;

    // Handshake: in_ready looks only at the registered count, so a full FIFO never
    // admits a push even when the head is popped in the same cycle.
    always_comb begin
        in_ready  = rst_n && (cnt_q != CntFull);
        out_valid = (cnt_q != '0);
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
    end

    // Count/pointer next state; flush wins over any concurrent push or pop.
    always_comb begin
        cnt_d = cnt_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (flush) begin
            cnt_d = '0;
            wr_d  = '0;
            rd_d  = '0;
        end else begin
            if (push) wr_d = wr_q + PtrOne;
            if (pop)  rd_d = rd_q + PtrOne;
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + CntOne;
                2'b01:   cnt_d = cnt_q - CntOne;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Count and pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
        end
    end

    // Entry storage; cleared on reset so the head reads zero afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imm_q <= '{default: '0};
            fmt_q <= '{default: '0};
            ill_q <= '{default: 1'b0};
            tag_q <= '{default: '0};
        end else if (push && !flush) begin
            imm_q[wr_q] <= exp_imm;
            fmt_q[wr_q] <= exp_fmt;
            ill_q[wr_q] <= exp_illegal;
            tag_q[wr_q] <= in_tag;
        end
    end

    // Head entry drives the outputs straight from registers; stable while stalled.
    always_comb begin
        out_imm     = imm_q[rd_q];
        out_fmt     = fmt_q[rd_q];
        out_illegal = ill_q[rd_q];
        out_tag     = tag_q[rd_q];
    end

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: three instances (RV32 auto, RV64 auto, RV32 explicit select)
// share one stimulus stream and are compared against a queue-based reference model.
module tb_imm_gen_stage;

    localparam int unsigned DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_inst = '0;
    logic [2:0]  in_sel = '0;
    logic [31:0] in_tag = '0;

    logic        rdy [3];
    logic        vld [3];
    logic        ill [3];
    logic [2:0]  fmt [3];
    logic [31:0] tag [3];
    logic [31:0] imm_a, imm_c;
    logic [63:0] imm_b;

    always #5 clk = ~clk;

    imm_gen_stage #(.XLEN(32), .DEPTH(DEPTH), .TAG_W(32), .AUTO_DECODE(1'b1)) u_a (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy[0]),
        .in_inst(in_inst), .in_sel(in_sel), .in_tag(in_tag), .out_valid(vld[0]),
        .out_ready(out_ready), .out_imm(imm_a), .out_fmt(fmt[0]), .out_illegal(ill[0]),
        .out_tag(tag[0])
    );
    imm_gen_stage #(.XLEN(64), .DEPTH(DEPTH), .TAG_W(32), .AUTO_DECODE(1'b1)) u_b (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy[1]),
        .in_inst(in_inst), .in_sel(in_sel), .in_tag(in_tag), .out_valid(vld[1]),
        .out_ready(out_ready), .out_imm(imm_b), .out_fmt(fmt[1]), .out_illegal(ill[1]),
        .out_tag(tag[1])
    );
    imm_gen_stage #(.XLEN(32), .DEPTH(DEPTH), .TAG_W(32), .AUTO_DECODE(1'b0)) u_c (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy[2]),
        .in_inst(in_inst), .in_sel(in_sel), .in_tag(in_tag), .out_valid(vld[2]),
        .out_ready(out_ready), .out_imm(imm_c), .out_fmt(fmt[2]), .out_illegal(ill[2]),
        .out_tag(tag[2])
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] inst;
        logic [2:0]  sel;
        logic [31:0] tag;
    } ent_t;
    ent_t q[$];

    typedef struct {
        logic [31:0] inst;
        logic [2:0]  sel;
        logic [63:0] imm32;
        logic [63:0] imm64;
        logic [63:0] immm;
        logic [2:0]  fmt_a;
        logic        ill_a;
        logic [2:0]  fmt_m;
    } vec_t;
    vec_t tv[9];

    int          cfg_xlen [3] = '{32, 64, 32};
    bit          cfg_auto [3] = '{1'b1, 1'b1, 1'b0};
    logic [6:0]  opc_list [9] = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
                                  7'b1100011, 7'b1101111, 7'b0110111, 7'b0010111,
                                  7'b1110011};

    function automatic logic [63:0] dut_imm(int d);
        if (d == 0) return {32'b0, imm_a};
        if (d == 1) return imm_b;
        return {32'b0, imm_c};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference expansion from the ISA field definitions using signed arithmetic.
    task automatic ref_expand(input logic [31:0] inst, input logic [2:0] sel, input int xlen,
                              input bit auto, output logic [63:0] imm, output logic [2:0] f,
                              output logic il);
        longint s;
        longint v;
        logic [6:0] opc;
        logic [2:0] f3;
        s   = longint'($signed(inst));
        opc = inst[6:0];
        f3  = inst[14:12];
        f   = sel;
        il  = 1'b0;
        if (auto) begin
            if (opc == 7'b0010011)                            f = (f3 == 3'd1 || f3 == 3'd5) ? 3'd5 : 3'd0;
            else if (opc == 7'b0000011 || opc == 7'b1100111)  f = 3'd0;
            else if (opc == 7'b0100011)                       f = 3'd1;
            else if (opc == 7'b1100011)                       f = 3'd2;
            else if (opc == 7'b1101111)                       f = 3'd3;
            else if (opc == 7'b0110111 || opc == 7'b0010111)  f = 3'd4;
            else if (opc == 7'b1110011)                       f = inst[14] ? 3'd6 : 3'd0;
            else begin f = 3'd7; il = 1'b1; end
        end
        case (f)
            3'd0: v = s >>> 20;
            3'd1: v = ((s >>> 25) << 5) | longint'(inst[11:7]);
            3'd2: v = ((s >>> 31) << 12) | (longint'(inst[7]) << 11)
                      | (longint'(inst[30:25]) << 5) | (longint'(inst[11:8]) << 1);
            3'd3: v = ((s >>> 31) << 20) | (longint'(inst[19:12]) << 12)
                      | (longint'(inst[20]) << 11) | (longint'(inst[30:21]) << 1);
            3'd4: v = (s >>> 12) << 12;
            3'd5: v = longint'(inst >> 20) % longint'(xlen);
            3'd6: v = longint'(inst >> 15) & 64'd31;
            default: v = 0;
        endcase
        if (xlen == 32) v = v & 64'hFFFF_FFFF;
        imm = 64'(v);
    endtask

    task automatic check_outputs();
        logic [63:0] ei;
        logic [2:0]  ef;
        logic        el;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("d%0d.in_ready", d), 64'(rdy[d]), 64'(q.size() < DEPTH));
            chk($sformatf("d%0d.out_valid", d), 64'(vld[d]), 64'(q.size() != 0));
            if (q.size() != 0) begin
                ref_expand(q[0].inst, q[0].sel, cfg_xlen[d], cfg_auto[d], ei, ef, el);
                chk($sformatf("d%0d.out_imm", d), dut_imm(d), ei);
                chk($sformatf("d%0d.out_fmt", d), 64'(fmt[d]), 64'(ef));
                chk($sformatf("d%0d.out_illegal", d), 64'(ill[d]), 64'(el));
                chk($sformatf("d%0d.out_tag", d), 64'(tag[d]), 64'(q[0].tag));
            end
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [2:0] sel,
                         input logic [31:0] t, input logic ordy, input logic fl);
        in_valid  = v;
        in_inst   = inst;
        in_sel    = sel;
        in_tag    = t;
        out_ready = ordy;
        flush     = fl;
    endtask

    // One clock: check at the current negedge, advance, then update the model queue.
    task automatic step();
        bit   acc;
        bit   pp;
        ent_t e;
        check_outputs();
        acc = in_valid && (q.size() < DEPTH) && !flush;
        pp  = out_ready && (q.size() != 0) && !flush;
        e   = '{inst: in_inst, sel: in_sel, tag: in_tag};
        @(posedge clk);
        if (flush) begin
            q.delete();
        end else begin
            if (pp)  void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        tv[0] = '{32'hFFF00093, 3'b000, 64'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF,
                  3'b000, 1'b0, 3'b000};
        tv[1] = '{32'hFE000EE3, 3'b010, 64'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 64'hFFFFFFFC,
                  3'b010, 1'b0, 3'b010};
        tv[2] = '{32'h800000B7, 3'b100, 64'h80000000, 64'hFFFFFFFF_80000000, 64'h80000000,
                  3'b100, 1'b0, 3'b100};
        tv[3] = '{32'h03F09093, 3'b101, 64'd31, 64'd63, 64'd31, 3'b101, 1'b0, 3'b101};
        tv[4] = '{32'h0000007F, 3'b111, 64'd0, 64'd0, 64'd0, 3'b111, 1'b1, 3'b111};
        tv[5] = '{32'h0002D073, 3'b110, 64'd5, 64'd5, 64'd5, 3'b110, 1'b0, 3'b110};
        tv[6] = '{32'hFE112C23, 3'b001, 64'hFFFFFFF8, 64'hFFFFFFFF_FFFFFFF8, 64'hFFFFFFF8,
                  3'b001, 1'b0, 3'b001};
        tv[7] = '{32'hFE112C23, 3'b000, 64'hFFFFFFF8, 64'hFFFFFFFF_FFFFFFF8, 64'hFFFFFFE1,
                  3'b001, 1'b0, 3'b000};
        tv[8] = '{32'hFF9FF06F, 3'b011, 64'hFFFFFFF8, 64'hFFFFFFFF_FFFFFFF8, 64'hFFFFFFF8,
                  3'b011, 1'b0, 3'b011};

        // Reset state
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst.d%0d.in_ready", d), 64'(rdy[d]), 64'd0);
            chk($sformatf("rst.d%0d.out_valid", d), 64'(vld[d]), 64'd0);
            chk($sformatf("rst.d%0d.out_imm", d), dut_imm(d), 64'd0);
            chk($sformatf("rst.d%0d.out_fmt", d), 64'(fmt[d]), 64'd0);
            chk($sformatf("rst.d%0d.out_illegal", d), 64'(ill[d]), 64'd0);
            chk($sformatf("rst.d%0d.out_tag", d), 64'(tag[d]), 64'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors: accepted at one edge, visible right after it
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, tv[i].inst, tv[i].sel, 32'(i + 16), 1'b1, 1'b0);
            step();
            drive(1'b0, 32'h0, 3'b000, 32'h0, 1'b1, 1'b0);
            chk($sformatf("vec%0d.valid", i), 64'(vld[0]), 64'd1);
            chk($sformatf("vec%0d.imm32", i), {32'b0, imm_a}, tv[i].imm32);
            chk($sformatf("vec%0d.imm64", i), imm_b, tv[i].imm64);
            chk($sformatf("vec%0d.imm_sel", i), {32'b0, imm_c}, tv[i].immm);
            chk($sformatf("vec%0d.fmt32", i), 64'(fmt[0]), 64'(tv[i].fmt_a));
            chk($sformatf("vec%0d.fmt64", i), 64'(fmt[1]), 64'(tv[i].fmt_a));
            chk($sformatf("vec%0d.fmt_sel", i), 64'(fmt[2]), 64'(tv[i].fmt_m));
            chk($sformatf("vec%0d.ill32", i), 64'(ill[0]), 64'(tv[i].ill_a));
            chk($sformatf("vec%0d.ill_sel", i), 64'(ill[2]), 64'd0);
            step();
        end

        // Backpressure: two accepts fill the FIFO, third offer is refused
        drive(1'b1, 32'hFFF00093, 3'b000, 32'hA1, 1'b0, 1'b0); step();
        drive(1'b1, 32'hFE000EE3, 3'b010, 32'hA2, 1'b0, 1'b0); step();
        chk("bp.full_in_ready", 64'(rdy[0]), 64'd0);
        drive(1'b1, 32'h800000B7, 3'b100, 32'hA3, 1'b0, 1'b0); step();
        // Full + pop + offered input: input refused, count 2 -> 1
        drive(1'b1, 32'h03F09093, 3'b101, 32'hA4, 1'b1, 1'b0); step();
        chk("bp.after_pop_ready", 64'(rdy[0]), 64'd1);
        chk("bp.after_pop_head_tag", 64'(tag[0]), 64'hA2);
        drive(1'b0, 32'h0, 3'b000, 32'h0, 1'b1, 1'b0);
        step(); step();

        // Flush with two entries held and a concurrent offer
        drive(1'b1, 32'h0002D073, 3'b110, 32'hB1, 1'b0, 1'b0); step();
        drive(1'b1, 32'hFE112C23, 3'b001, 32'hB2, 1'b0, 1'b0); step();
        drive(1'b1, 32'hFF9FF06F, 3'b011, 32'hB3, 1'b0, 1'b1); step();
        drive(1'b0, 32'h0, 3'b000, 32'h0, 1'b1, 1'b0);
        chk("flush.out_valid", 64'(vld[0]), 64'd0);
        step(); step();

        // Reset mid-stream with two entries held
        drive(1'b1, 32'hFFF00093, 3'b000, 32'hC1, 1'b0, 1'b0); step();
        drive(1'b1, 32'h800000B7, 3'b100, 32'hC2, 1'b0, 1'b0); step();
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("midrst.d%0d.out_valid", d), 64'(vld[d]), 64'd0);
            chk($sformatf("midrst.d%0d.in_ready", d), 64'(rdy[d]), 64'd0);
        end
        q.delete();
        drive(1'b0, 32'h0, 3'b000, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst.release_ready", 64'(rdy[0]), 64'd1);
        @(negedge clk);
        step();

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            r = $urandom;
            if ($urandom_range(0, 3) != 0) r[6:0] = opc_list[$urandom_range(0, 8)];
            drive(1'($urandom_range(0, 1)), r, 3'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
            step();
        end
        drive(1'b0, 32'h0, 3'b000, 32'h0, 1'b1, 1'b0);
        step(); step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
